jace_ps2_keyboard: RTL and testbench

//  PS/2 keyboard front end for the Jupiter Ace core; sits directly upstream of jace_logic's kbdcols input.

---
 rtl/jace_ps2_keyboard_pkg.sv | 30 +++
 rtl/jace_ps2_rx.sv | 106 ++++++++++
 rtl/jace_ps2_keyboard.sv | 128 ++++++++++++
 tb/tb_jace_ps2_keyboard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jace_ps2_keyboard_pkg.sv
// Shared constants and types for the Jupiter Ace PS/2 keyboard front end.
// Holds the set-2 prefix codes, special key codes and the keymap result record.
package jace_ps2_keyboard_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;
  localparam logic [7:0] PS2_F12 = 8'h07;
  localparam logic [7:0] PS2_SYM = 8'h14;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 5;

  localparam logic [2:0] ROW_SYM = 3'd0;
  localparam logic [2:0] COL_SYM = 3'd1;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t key_at(input logic [2:0] r, input logic [2:0] c);
    key_pos_t k;
    k.hit = 1'b1;
    k.row = r;
    k.col = c;
    return k;
  endfunction

endpackage

// File: rtl/jace_ps2_rx.sv
// PS/2 byte receiver: pin synchronisers, ps2clk glitch filter, frame FSM and
// mid-frame timeout. Emits a one-clock valid pulse per good byte, error per bad one.
module jace_ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 13000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2clk,
  input  logic       i_ps2data,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;
  localparam int         TW        = $clog2(TIMEOUT + 1);

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_dat_sync;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_clk_filt;
  logic [1:0]            r_state;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  r_parity;
  logic [TW-1:0]         r_tmo;
  logic                  w_fall;
  logic                  w_dat;

  // One-cycle strobe on the cycle the filtered clock is about to drop.
  assign w_fall = r_clk_filt && (r_filt == '0);
  assign w_dat  = r_dat_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= '1;
      r_clk_filt <= 1'b1;
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tmo      <= '0;
      o_byte     <= '0;
      o_valid    <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2data};
      r_filt     <= {r_filt[FILTER_LEN-2:0], r_clk_sync[1]};
      if (r_filt == '1) begin
        r_clk_filt <= 1'b1;
      end else if (r_filt == '0) begin
        r_clk_filt <= 1'b0;
      end
      o_valid <= 1'b0;
      o_error <= 1'b0;
      if (w_fall) begin
        r_tmo <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!w_dat) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
              r_parity  <= 1'b0;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_parity  <= r_parity ^ w_dat;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_parity <= r_parity ^ w_dat;
            r_state  <= ST_STOP;
          end
          default: begin
            r_state <= ST_IDLE;
            o_byte  <= r_shift;
            if (r_parity && w_dat) begin
              o_valid <= 1'b1;
            end else begin
              o_error <= 1'b1;
            end
          end
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_state <= ST_IDLE;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/jace_ps2_keyboard.sv
// Set-2 scan code decoder driving the 8x5 Jupiter Ace key matrix, answering the
// CPU row scan with active-low columns and flagging F12 as a user reset request.
module jace_ps2_keyboard
  import jace_ps2_keyboard_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 13000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] rows,
  output logic [4:0] kbdcols,
  output logic       user_reset
);

  logic [7:0]                          w_byte;
  logic                                w_valid;
  logic                                w_error;
  key_pos_t                            w_key;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]   r_matrix;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]   w_masked;
  logic [NUM_COLS-1:0]                 w_any;
  logic                                r_ext;
  logic                                r_rel;
  logic                                r_user_reset;

  jace_ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ps2clk (ps2clk),
    .i_ps2data(ps2data),
    .o_byte   (w_byte),
    .o_valid  (w_valid),
    .o_error  (w_error)
  );

  function automatic key_pos_t keymap(input logic ext, input logic [7:0] code);
    key_pos_t k;
    k = '0;
    if (ext) begin
      if (code == PS2_SYM) k = key_at(ROW_SYM, COL_SYM);
    end else begin
      case (code)
        8'h12, 8'h59: k = key_at(3'd0, 3'd0);
        8'h14: k = key_at(3'd0, 3'd1);  8'h1A: k = key_at(3'd0, 3'd2);
        8'h22: k = key_at(3'd0, 3'd3);  8'h21: k = key_at(3'd0, 3'd4);
        8'h1C: k = key_at(3'd1, 3'd0);  8'h1B: k = key_at(3'd1, 3'd1);
        8'h23: k = key_at(3'd1, 3'd2);  8'h2B: k = key_at(3'd1, 3'd3);
        8'h34: k = key_at(3'd1, 3'd4);
        8'h15: k = key_at(3'd2, 3'd0);  8'h1D: k = key_at(3'd2, 3'd1);
        8'h24: k = key_at(3'd2, 3'd2);  8'h2D: k = key_at(3'd2, 3'd3);
        8'h2C: k = key_at(3'd2, 3'd4);
        8'h16: k = key_at(3'd3, 3'd0);  8'h1E: k = key_at(3'd3, 3'd1);
        8'h26: k = key_at(3'd3, 3'd2);  8'h25: k = key_at(3'd3, 3'd3);
        8'h2E: k = key_at(3'd3, 3'd4);
        8'h45: k = key_at(3'd4, 3'd0);  8'h46: k = key_at(3'd4, 3'd1);
        8'h3E: k = key_at(3'd4, 3'd2);  8'h3D: k = key_at(3'd4, 3'd3);
        8'h36: k = key_at(3'd4, 3'd4);
        8'h4D: k = key_at(3'd5, 3'd0);  8'h44: k = key_at(3'd5, 3'd1);
        8'h43: k = key_at(3'd5, 3'd2);  8'h3C: k = key_at(3'd5, 3'd3);
        8'h35: k = key_at(3'd5, 3'd4);
        8'h5A: k = key_at(3'd6, 3'd0);  8'h4B: k = key_at(3'd6, 3'd1);
        8'h42: k = key_at(3'd6, 3'd2);  8'h3B: k = key_at(3'd6, 3'd3);
        8'h33: k = key_at(3'd6, 3'd4);
        8'h29: k = key_at(3'd7, 3'd0);  8'h3A: k = key_at(3'd7, 3'd1);
        8'h31: k = key_at(3'd7, 3'd2);  8'h32: k = key_at(3'd7, 3'd3);
        8'h2A: k = key_at(3'd7, 3'd4);
        default: k = '0;
      endcase
    end
    return k;
  endfunction

  assign w_key = keymap(r_ext, w_byte);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_matrix     <= '0;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
      r_user_reset <= 1'b0;
    end else begin
      r_user_reset <= 1'b0;
      if (w_error) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end else if (w_valid) begin
        if (w_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == PS2_REL) begin
          r_rel <= 1'b1;
        end else begin
          if (w_key.hit) begin
            r_matrix[w_key.row][w_key.col] <= ~r_rel;
          end
          if (!r_ext && !r_rel && (w_byte == PS2_F12)) begin
            r_user_reset <= 1'b1;
          end
          r_ext <= 1'b0;
          r_rel <= 1'b0;
        end
      end
    end
  end

  // Every selected row ORs into the column read-back, ghosting like a passive matrix.
  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign w_masked[gi] = rows[gi] ? '0 : r_matrix[gi];
    end
  endgenerate

  always_comb begin
    w_any = '0;
    for (int n = 0; n < NUM_ROWS; n++) begin
      w_any = w_any | w_masked[n];
    end
  end

  assign kbdcols    = ~w_any;
  assign user_reset = r_user_reset;

endmodule

// File: tb/tb_jace_ps2_keyboard.sv
// Bench for jace_ps2_keyboard: table-driven directed vectors, hand-written corner
// sequences, then random scan-code traffic against a key-set reference model.
module tb_jace_ps2_keyboard;

  localparam int TIMEOUT = 13000;
  localparam int HP      = 12;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       ps2clk  = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] rows    = 8'hFF;
  logic [4:0] kbdcols;
  logic       user_reset;

  jace_ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .rows      (rows),
    .kbdcols   (kbdcols),
    .user_reset(user_reset)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int ur_cnt = 0;

  always @(negedge clk) if (user_reset === 1'b1) ur_cnt++;

  // Key positions in row-major order (row*5 + col).
  logic [7:0] key_tbl [40] = '{
    8'h12, 8'h14, 8'h1A, 8'h22, 8'h21,  8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,  8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,  8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A};
  logic [7:0] unmapped [6] = '{8'h76, 8'h05, 8'h0E, 8'h66, 8'h0D, 8'h58};

  bit m_keys [40];
  bit m_ext;
  bit m_rel;

  function automatic int lookup(input bit ext, input logic [7:0] b);
    if (ext) return (b == 8'h14) ? 1 : -1;
    if (b == 8'h59) return 0;
    for (int i = 0; i < 40; i++) if (key_tbl[i] == b) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 40; i++) m_keys[i] = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    int idx;
    if (!good) begin
      m_ext = 1'b0; m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      idx = lookup(m_ext, b);
      if (idx >= 0) m_keys[idx] = !m_rel;
      m_ext = 1'b0; m_rel = 1'b0;
    end
  endtask

  function automatic logic [4:0] model_cols(input logic [7:0] r);
    logic [4:0] res;
    res = 5'b11111;
    for (int c = 0; c < 5; c++)
      for (int n = 0; n < 8; n++)
        if (!r[n] && m_keys[n*5 + c]) res[c] = 1'b0;
    return res;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end else begin
      $display("chk %s: got %h ok", name, got);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badpar, input int nbits,
                            input int pause_at, input int pause_len);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == pause_at) repeat (pause_len) @(negedge clk);
      ps2data = fr[i];
      repeat (HP) @(negedge clk);
      ps2clk = 1'b0;
      repeat (HP) @(negedge clk);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
    repeat (3*HP) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit badpar);
    send_frame(b, badpar, 11, -1, 0);
    model_byte(b, !badpar);
  endtask

  task automatic chk_rows(input string name, input logic [7:0] r, input logic [4:0] exp);
    rows = r;
    @(negedge clk);
    check(name, 8'(kbdcols), 8'(exp));
  endtask

  typedef struct {
    int             n;
    logic [2:0][7:0] bs;
    logic [7:0]     rows;
    logic [4:0]     exp;
    string          name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] r, input logic [4:0] e,
                         input string name);
    vec_t v;
    v.n = n; v.bs[0] = b0; v.bs[1] = b1; v.bs[2] = b2;
    v.rows = r; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    int ur0;
    int sel;
    int k;
    logic [7:0] rv;
    logic [7:0] code;

    model_clear();
    repeat (5) @(negedge clk);
    rows = 8'h00;
    @(negedge clk);
    check("rst_cols", 8'(kbdcols), 8'h1F);
    check("rst_ureset", 8'(user_reset), 8'h00);
    rst_n = 1'b1;
    rows  = 8'hFF;
    repeat (5) @(negedge clk);

    add_vec(1, 8'h1C, 8'h00, 8'h00, 8'hFD, 5'b11110, "a_press");
    add_vec(0, 8'h00, 8'h00, 8'h00, 8'hFF, 5'b11111, "rows_ff");
    add_vec(2, 8'hF0, 8'h1C, 8'h00, 8'hFD, 5'b11111, "a_release");
    add_vec(1, 8'h12, 8'h00, 8'h00, 8'hFE, 5'b11110, "shift");
    add_vec(1, 8'h1A, 8'h00, 8'h00, 8'hFE, 5'b11010, "shift_z");
    add_vec(0, 8'h00, 8'h00, 8'h00, 8'h7F, 5'b11111, "row7_clear");
    add_vec(2, 8'hF0, 8'h12, 8'h00, 8'hFE, 5'b11011, "shift_rel");
    add_vec(2, 8'hF0, 8'h1A, 8'h00, 8'hFE, 5'b11111, "z_rel");
    add_vec(2, 8'hE0, 8'h14, 8'h00, 8'hFE, 5'b11101, "sym_ext");
    add_vec(3, 8'hE0, 8'hF0, 8'h14, 8'hFE, 5'b11111, "sym_ext_rel");
    add_vec(1, 8'h59, 8'h00, 8'h00, 8'hFE, 5'b11110, "rshift");
    add_vec(2, 8'hF0, 8'h12, 8'h00, 8'hFE, 5'b11111, "lshift_rel");
    add_vec(2, 8'hE0, 8'h1C, 8'h00, 8'hFD, 5'b11111, "ext_unmapped");
    add_vec(1, 8'h16, 8'h00, 8'h00, 8'hF7, 5'b11110, "key1");
    add_vec(1, 8'h45, 8'h00, 8'h00, 8'hEF, 5'b11110, "key0");
    add_vec(0, 8'h00, 8'h00, 8'h00, 8'hE7, 5'b11110, "ghost_or");
    add_vec(1, 8'h2E, 8'h00, 8'h00, 8'hE7, 5'b01110, "key5_or");

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].bs[j], 1'b0);
      chk_rows(vecs[i].name, vecs[i].rows, vecs[i].exp);
    end

    // Reset with keys held: columns released on the very next clock.
    rows = 8'hE7;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid", 8'(kbdcols), 8'h1F);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (5) @(negedge clk);

    send_byte(8'h1C, 1'b1);
    chk_rows("badpar_drop", 8'hFD, 5'b11111);
    send_byte(8'h1B, 1'b0);
    chk_rows("after_bad_s", 8'hFD, 5'b11101);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1B, 1'b0);
    chk_rows("s_rel", 8'hFD, 5'b11111);

    send_byte(8'hF0, 1'b0);
    send_byte(8'h55, 1'b1);
    send_byte(8'h1C, 1'b0);
    chk_rows("bad_clr_rel", 8'hFD, 5'b11110);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    chk_rows("a_rel2", 8'hFD, 5'b11111);

    send_frame(8'h1C, 1'b0, 5, -1, 0);
    repeat (TIMEOUT + 100) @(negedge clk);
    send_byte(8'h29, 1'b0);
    chk_rows("timeout_space", 8'h7F, 5'b11110);
    chk_rows("timeout_row1", 8'hFD, 5'b11111);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    chk_rows("space_rel", 8'h7F, 5'b11111);

    send_frame(8'h1C, 1'b0, 11, 5, TIMEOUT - 500);
    model_byte(8'h1C, 1'b1);
    chk_rows("slow_frame", 8'hFD, 5'b11110);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);

    ur0 = ur_cnt;
    send_byte(8'h07, 1'b0);
    check("f12_pulse", 8'(ur_cnt - ur0), 8'd1);
    ur0 = ur_cnt;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h07, 1'b0);
    check("f12_rel_ext", 8'(ur_cnt - ur0), 8'd0);
    chk_rows("f12_matrix", 8'h00, 5'b11111);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: send_byte(8'($urandom_range(0, 255)), 1'b1);
        1: send_byte(unmapped[$urandom_range(0, 5)], 1'b0);
        2: begin
          if ($urandom_range(0, 1) == 1) send_byte(8'hE0, 1'b0);
          if ($urandom_range(0, 1) == 1) send_byte(8'hF0, 1'b0);
          send_byte(($urandom_range(0, 1) == 1) ? 8'h14 : 8'h1C, 1'b0);
        end
        default: begin
          k = $urandom_range(0, 40);
          code = (k == 40) ? 8'h59 : key_tbl[k];
          if ($urandom_range(0, 2) == 0) send_byte(8'hF0, 1'b0);
          send_byte(code, 1'b0);
        end
      endcase
      if ($urandom_range(0, 1) == 1) rv = ~(8'h01 << $urandom_range(0, 7));
      else rv = 8'($urandom_range(0, 255));
      chk_rows($sformatf("rand%0d_rows%h", t, rv), rv, model_cols(rv));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
